// File: rtl/display_arbiter.sv
// Display arbiter for the reaction game's 4-digit seven-segment display.
// Picks menu, timer, result or score content with priority, dwell and blink.
//
// Ports:
//   clk_500Hz, rst            display clock, async active-high reset
//   req_menu, menu_mode       menu request and selected difficulty
//   req_timer, timer_val      live reaction timer request and value
//   res_pulse, res_val        one-cycle result strobe and value
//   req_score, score_val      high score request and value
//   number, select, mode      digit multiplexer inputs
//   blank                     1 = all digits dark
//   res_ack                   one-cycle acknowledge of a captured result
module display_arbiter #(
  parameter int NUM_W        = 14,
  parameter int HOLD_TICKS   = 250,
  parameter int RESULT_TICKS = 1000,
  parameter int BLINK_TICKS  = 125
) (
  input  logic             clk_500Hz,
  input  logic             rst,
  input  logic             req_menu,
  input  logic [1:0]       menu_mode,
  input  logic             req_timer,
  input  logic [NUM_W-1:0] timer_val,
  input  logic             res_pulse,
  input  logic [NUM_W-1:0] res_val,
  input  logic             req_score,
  input  logic [NUM_W-1:0] score_val,
  output logic [NUM_W-1:0] number,
  output logic [1:0]       select,
  output logic [1:0]       mode,
  output logic             blank,
  output logic             res_ack
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int RW = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MENU   = 3'd1;
  localparam logic [2:0] S_TIMER  = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_SCORE  = 3'd4;

  logic [2:0]       state, nxt, want, tgt;
  logic [HW-1:0]    hold_cnt, hold_n;
  logic [RW-1:0]    res_cnt, res_n;
  logic [BW-1:0]    blink_cnt, blink_n;
  logic [NUM_W-1:0] res_latch, latch_n;
  logic [NUM_W-1:0] number_n;
  logic [1:0]       select_n, mode_n;
  logic             blank_n, ack_n;
  logic             holding;

  // Preemption rank of the non-result sources; IDLE ranks lowest.
  function automatic logic [1:0] rank(input logic [2:0] s);
    case (s)
      S_TIMER: rank = 2'd3;
      S_SCORE: rank = 2'd2;
      S_MENU:  rank = 2'd1;
      default: rank = 2'd0;
    endcase
  endfunction

  always_comb begin
    want = S_IDLE;
    priority case (1'b1)
      req_timer: want = S_TIMER;
      req_score: want = S_SCORE;
      req_menu:  want = S_MENU;
      default:   want = S_IDLE;
    endcase
  end

  assign holding = (state == S_MENU || state == S_TIMER ||
                    state == S_SCORE) && (hold_cnt != '0);

  always_comb begin
    nxt      = state;
    tgt      = state;
    hold_n   = hold_cnt;
    res_n    = res_cnt;
    blink_n  = blink_cnt;
    latch_n  = res_latch;
    number_n = number;
    select_n = select;
    mode_n   = mode;
    blank_n  = blank;
    ack_n    = 1'b0;
    if (res_pulse) begin
      nxt      = S_RESULT;
      latch_n  = res_val;
      res_n    = RW'(RESULT_TICKS - 1);
      blink_n  = '0;
      hold_n   = '0;
      blank_n  = 1'b0;
      ack_n    = 1'b1;
      number_n = res_val;
      select_n = 2'd2;
    end else if (state == S_RESULT && res_cnt != '0) begin
      res_n = res_cnt - 1'b1;
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_n = '0;
        blank_n = ~blank;
      end else begin
        blink_n = blink_cnt + 1'b1;
      end
    end else begin
      // During a hold only a strictly higher rank may take over.
      tgt = want;
      if (holding && rank(want) <= rank(state))
        tgt = state;
      if (tgt == state)
        hold_n = (hold_cnt != '0) ? hold_cnt - 1'b1 : '0;
      else if (tgt == S_IDLE)
        hold_n = '0;
      else
        hold_n = HW'(HOLD_TICKS - 1);
      nxt = tgt;
      unique case (tgt)
        S_MENU: begin
          number_n = '0;
          select_n = 2'd0;
          mode_n   = menu_mode;
          blank_n  = 1'b0;
        end
        S_TIMER: begin
          number_n = timer_val;
          select_n = 2'd1;
          blank_n  = 1'b0;
        end
        S_SCORE: begin
          number_n = score_val;
          select_n = 2'd3;
          blank_n  = 1'b0;
        end
        default: begin
          number_n = '0;
          select_n = 2'd0;
          blank_n  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      res_cnt   <= '0;
      blink_cnt <= '0;
      res_latch <= '0;
      number    <= '0;
      select    <= 2'd0;
      mode      <= 2'd0;
      blank     <= 1'b1;
      res_ack   <= 1'b0;
    end else begin
      state     <= nxt;
      hold_cnt  <= hold_n;
      res_cnt   <= res_n;
      blink_cnt <= blink_n;
      res_latch <= latch_n;
      number    <= number_n;
      select    <= select_n;
      mode      <= mode_n;
      blank     <= blank_n;
      res_ack   <= ack_n;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter: directed steps then random traffic,
// compared each cycle with a dwell/age based reference model.
module tb_display_arbiter;

  localparam int NUM_W = 14;
  localparam int HOLD  = 4;
  localparam int RES_T = 16;
  localparam int BLINK = 2;

  // model source codes
  localparam int M_IDLE = 0, M_MENU = 1, M_TIMER = 2;
  localparam int M_RESULT = 3, M_SCORE = 4;

  logic             clk_500Hz = 1'b0;
  logic             rst;
  logic             req_menu, req_timer, req_score, res_pulse;
  logic [1:0]       menu_mode;
  logic [NUM_W-1:0] timer_val, res_val, score_val;
  logic [NUM_W-1:0] number;
  logic [1:0]       select, mode;
  logic             blank, res_ack;

  int checks = 0;
  int errors = 0;

  int m_src, m_age, m_res;
  int m_num, m_sel, m_mode, m_blank, m_ack;

  display_arbiter #(
    .NUM_W(NUM_W),
    .HOLD_TICKS(HOLD),
    .RESULT_TICKS(RES_T),
    .BLINK_TICKS(BLINK)
  ) dut (
    .clk_500Hz(clk_500Hz),
    .rst(rst),
    .req_menu(req_menu),
    .menu_mode(menu_mode),
    .req_timer(req_timer),
    .timer_val(timer_val),
    .res_pulse(res_pulse),
    .res_val(res_val),
    .req_score(req_score),
    .score_val(score_val),
    .number(number),
    .select(select),
    .mode(mode),
    .blank(blank),
    .res_ack(res_ack)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rank(input int s);
    if (s == M_TIMER) return 3;
    if (s == M_SCORE) return 2;
    if (s == M_MENU) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_src = M_IDLE; m_age = 0; m_res = 0;
    m_num = 0; m_sel = 0; m_mode = 0; m_blank = 1; m_ack = 0;
  endtask

  // One clock edge: decide the source from the sampled inputs,
  // tracking how many cycles the current source has been shown.
  task automatic model_step();
    int want, tgt;
    bit hold_on;
    m_ack = 0;
    if (res_pulse) begin
      m_src = M_RESULT; m_age = 0; m_res = int'(res_val); m_ack = 1;
    end else if (m_src == M_RESULT && m_age < RES_T - 1) begin
      m_age++;
    end else begin
      want = req_timer ? M_TIMER : req_score ? M_SCORE :
             req_menu ? M_MENU : M_IDLE;
      hold_on = (m_src == M_MENU || m_src == M_TIMER ||
                 m_src == M_SCORE) && (m_age < HOLD - 1);
      tgt = want;
      if (hold_on && rank(want) <= rank(m_src)) tgt = m_src;
      if (tgt == m_src) m_age++;
      else m_age = 0;
      m_src = tgt;
    end
    case (m_src)
      M_RESULT: begin
        m_num = m_res; m_sel = 2; m_blank = (m_age / BLINK) % 2;
      end
      M_TIMER: begin m_num = int'(timer_val); m_sel = 1; m_blank = 0; end
      M_SCORE: begin m_num = int'(score_val); m_sel = 3; m_blank = 0; end
      M_MENU: begin
        m_num = 0; m_sel = 0; m_blank = 0; m_mode = int'(menu_mode);
      end
      default: begin m_num = 0; m_sel = 0; m_blank = 1; end
    endcase
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".number"}, 32'(number), 32'(m_num));
    chk({tag, ".select"}, 32'(select), 32'(m_sel));
    chk({tag, ".mode"}, 32'(mode), 32'(m_mode));
    chk({tag, ".blank"}, 32'(blank), 32'(m_blank));
    chk({tag, ".res_ack"}, 32'(res_ack), 32'(m_ack));
  endtask

  task automatic tick(input string tag);
    @(posedge clk_500Hz);
    model_step();
    #1;
    chk_all(tag);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".number"}, 32'(number), 32'd0);
    chk({tag, ".select"}, 32'(select), 32'd0);
    chk({tag, ".mode"}, 32'(mode), 32'd0);
    chk({tag, ".blank"}, 32'(blank), 32'd1);
    chk({tag, ".res_ack"}, 32'(res_ack), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_menu = 0; req_timer = 0; req_score = 0; res_pulse = 0;
    menu_mode = 0; timer_val = 0; res_val = 0; score_val = 0;
    model_reset();
    #2;
    chk_reset("reset");
    @(negedge clk_500Hz);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) tick("idle");

    // menu request for one cycle, then the hold keeps it shown
    req_menu = 1; menu_mode = 2'd2;
    tick("menu_on");
    chk("menu_sel", 32'(select), 32'd0);
    chk("menu_blank", 32'(blank), 32'd0);
    req_menu = 0;
    for (int i = 0; i < 6; i++) tick("menu_hold");
    chk("menu_gone", 32'(blank), 32'd1);

    // timer preempts menu inside its hold
    req_menu = 1;
    tick("menu_again");
    req_timer = 1;
    for (int i = 0; i <= 20; i++) begin
      timer_val = NUM_W'(100 + i);
      tick("timer_ramp");
    end
    chk("timer_num", 32'(number), 32'd120);

    // result during timer, re-triggered at its 9th cycle
    res_val = NUM_W'(347); res_pulse = 1;
    tick("res1");
    chk("res1_num", 32'(number), 32'd347);
    chk("res1_ack", 32'(res_ack), 32'd1);
    res_pulse = 0;
    for (int i = 0; i < 8; i++) tick("res1_run");
    res_val = NUM_W'(512); res_pulse = 1;
    tick("res2");
    chk("res2_blank", 32'(blank), 32'd0);
    res_pulse = 0; res_val = 0;
    for (int i = 0; i < 19; i++) tick("res2_run");
    chk("res_back_timer", 32'(select), 32'd1);

    // score and menu together; score outranks menu
    req_timer = 0; req_score = 1; req_menu = 1;
    score_val = NUM_W'(9999);
    for (int i = 0; i < 6; i++) tick("score");
    chk("score_sel", 32'(select), 32'd3);
    chk("score_num", 32'(number), 32'd9999);

    // async reset in the middle of a hold
    req_score = 0; req_menu = 0; req_timer = 1;
    tick("pre_rst");
    #2 rst = 1'b1;
    #1 chk_reset("mid_rst");
    model_reset();
    @(negedge clk_500Hz);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) req_menu = ~req_menu;
      if ($urandom_range(0, 9) == 0) req_timer = ~req_timer;
      if ($urandom_range(0, 7) == 0) req_score = ~req_score;
      res_pulse = ($urandom_range(0, 24) == 0);
      res_val   = NUM_W'($urandom_range(0, 9999));
      timer_val = NUM_W'($urandom_range(0, 9999));
      score_val = NUM_W'($urandom_range(0, 9999));
      menu_mode = 2'($urandom_range(0, 3));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Arbitrates the reaction game's single 4-digit seven-segment display between four content sources: mode menu, live reaction timer, latched result, and high score.
- Applies fixed priority, minimum dwell times and result blinking.
- Drives the number, select and mode inputs of the digit multiplexer, plus a blank strobe that gates its anodes.
- Runs in the 500 Hz display clock domain.

Parameters:
- NUM_W, 14, width of all displayed values (0..9999)
- HOLD_TICKS, 250, minimum clk_500Hz cycles a granted non-result source keeps the display (0.5 s)
- RESULT_TICKS, 1000, cycles a captured result is shown (2 s)
- BLINK_TICKS, 125, half-period of the result blink, in cycles

Ports:
- clk_500Hz  in  1  display/multiplex clock
- rst  in  1  reset, asynchronous, active-high
- req_menu  in  1  level request; menu wants the display
- menu_mode  in  2  menu selection (0 easy, 1 regular, 2 hard)
- req_timer  in  1  level request; reaction timer running
- timer_val  in  NUM_W  live timer value, ms
- res_pulse  in  1  one-cycle strobe; new result available
- res_val  in  NUM_W  result value, valid when res_pulse=1
- req_score  in  1  level request; show high score
- score_val  in  NUM_W  high score value
- number  out  NUM_W  value to display
- select  out  2  0 menu/letters, 1 timer, 2 result, 3 score
- mode  out  2  mode passed to the letter display
- blank  out  1  1 = all digits dark
- res_ack  out  1  one-cycle acknowledge of res_pulse capture

Behaviour:
- Clock and reset: reset rst, asynchronous, active-high; clock clk_500Hz. All outputs registered.
- Reset values: state IDLE; number=0, select=0, mode=0, blank=1, res_ack=0; hold, result and blink counters 0; result latch 0.
- States: IDLE, MENU, TIMER, RESULT, SCORE.
- Priority: RESULT > TIMER > SCORE > MENU.
- Latency: inputs sampled at edge N; outputs reflect the decision at edge N+1.
- res_pulse, in any state including RESULT:
  - Latch res_val; res_ack=1 for exactly that one cycle.
  - Enter or re-enter RESULT; result counter loads RESULT_TICKS-1; blink counter and blank clear to 0.
  - This overrides any hold in progress.
- RESULT:
  - number=latched result; select=2.
  - blank toggles each time the blink counter reaches BLINK_TICKS-1; that counter then wraps to 0.
  - When the result counter reaches 0 and no new res_pulse arrives, run normal arbitration, ignoring hold.
- Non-result grant (MENU, TIMER, SCORE):
  - On entry, hold counter loads HOLD_TICKS-1; blank=0.
  - Counter decrements each cycle while above 0.
- Switching while hold > 0: only to a higher-priority requester.
  - Example: TIMER preempts SCORE and MENU.
  - MENU never preempts.
  - A deasserted own request is ignored until hold reaches 0.
- Switching at hold = 0: arbitrate among active requests by priority.
  - Staying in the same source does not reload hold.
- Outputs per state:
  - MENU: select=0; mode=menu_mode, tracked every cycle.
  - TIMER: select=1; number=timer_val, re-registered every cycle.
  - SCORE: select=3; number=score_val, tracked every cycle.
- No request and hold expired: go to IDLE; blank=1, number=0, select=0.
- Simultaneous events:
  - res_pulse wins over any level request on the same edge.
  - On simultaneous level requests, the highest priority wins.
- Counter widths: wide enough for their parameter, minimum 1 bit. No overflow is possible; counters saturate at 0.
- rst mid-operation: immediate return to reset values; the latched result is cleared.
- Invalid menu_mode=3 passes through unchanged; the letter display blanks it.

Test Plan:
Bench uses HOLD_TICKS=4, RESULT_TICKS=16, BLINK_TICKS=2.
- rst released, no requests -> blank=1, select=0, number=0; IDLE held for 20 cycles.
- req_menu=1, menu_mode=2 -> one cycle later select=0, mode=2, blank=0. Drop req_menu on the next cycle -> display holds 4 cycles total, then returns to blank=1.
- MENU active, req_timer=1, timer_val ramping 100..120 -> select=1 at N+1 (preemption inside hold); number follows timer_val with 1-cycle lag.
- res_pulse with res_val=347 during TIMER -> res_ack=1 for one cycle; select=2, number=347; blank pattern 0,0,1,1,... over 16 cycles; then back to select=1 if req_timer is still high.
- Second res_pulse, res_val=512, at cycle 9 of RESULT -> number=512; a fresh 16-cycle window starts; blank restarts at 0.
- req_score and req_menu asserted on the same edge, score_val=9999 -> select=3, number=9999. Assert rst mid-hold -> all outputs at reset values in the same cycle.
